// File: rtl/data_ram_responder.sv
// Single-port word RAM behind a fixed-latency request/response handshake.
// One transfer is in flight at a time: accepted in IDLE, timed through WAIT
// by a 4-bit down-counter, answered with a one-cycle pulse in RESP.
module data_ram_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_request,
  input  logic [31:0] d_address,
  input  logic        d_write_enable,
  input  logic [31:0] d_data_write,
  output logic [31:0] d_data_read,
  output logic        d_data_valid,
  output logic        d_error,
  output logic        d_busy
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  // WAIT lasts LATENCY-1 cycles; the counter runs LATENCY-2 .. 0.
  localparam logic [3:0]  WAIT_LOAD  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      cnt_reg, cnt_next;

  // Transfer captured at acceptance
  logic [AW-1:0]   idx_reg;
  logic            we_reg;
  logic            err_reg;
  logic [31:0]     wdata_reg;

  // Transfer as seen on the edge entering RESP: taken straight from the
  // inputs when that edge is also the acceptance edge (LATENCY=1).
  logic [AW-1:0]   cur_idx;
  logic            cur_we;
  logic            cur_err;
  logic [31:0]     cur_wdata;

  logic            req_err;
  logic            accept;
  logic            enter_resp;
  logic            mem_we;

  logic [31:0]     mem [DEPTH_WORDS];

  // Request decode and selection of the transfer being answered
  always_comb begin
    req_err = (d_address[1:0] != 2'b00) || (d_address >= ADDR_LIMIT);
    accept  = (state_reg == IDLE) && d_request;
    if (state_reg == IDLE) begin
      cur_idx   = d_address[AW+1:2];
      cur_we    = d_write_enable;
      cur_err   = req_err;
      cur_wdata = d_data_write;
    end else begin
      cur_idx   = idx_reg;
      cur_we    = we_reg;
      cur_err   = err_reg;
      cur_wdata = wdata_reg;
    end
  end

  // Next-state logic and WAIT countdown
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (d_request) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
    enter_resp = (state_next == RESP);
    // Gated by reset so a reset coinciding with the commit edge writes nothing.
    mem_we     = enter_resp && cur_we && !cur_err && !reset;
  end

  // State, counter, captured transfer and registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      we_reg       <= 1'b0;
      err_reg      <= 1'b0;
      wdata_reg    <= 32'd0;
      d_data_valid <= 1'b0;
      d_error      <= 1'b0;
      d_data_read  <= 32'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        idx_reg   <= d_address[AW+1:2];
        we_reg    <= d_write_enable;
        err_reg   <= req_err;
        wdata_reg <= d_data_write;
      end
      d_data_valid <= enter_resp;
      d_error      <= enter_resp && cur_err;
      // Reads sample the array before this edge's (absent) write, i.e. the
      // value as of acceptance; writes and rejected transfers return 0.
      d_data_read  <= (enter_resp && !cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
    end
  end

  // Array write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign d_busy = (state_reg != IDLE);

endmodule
